// File: rtl/h2c_pkg.sv
// rtl/h2c_pkg.sv - shared header layout, state encoding and error bit indices for the H2C unpacker
package h2c_pkg;

  localparam int FIELD_W       = 16;
  localparam int HDR_MAGIC_LSB = 0;
  localparam int HDR_LEN_LSB   = 16;
  localparam int HDR_SEQ_LSB   = 32;

  localparam logic [15:0] MAGIC_DEFAULT = 16'hA5C3;

  localparam int ERR_MAGIC = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_SEQ   = 2;
  localparam int ERR_W     = 3;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY  = 2'd1,
    S_DROP = 2'd2
  } h2c_state_e;

endpackage

// File: rtl/h2c_sync_fifo.sv
// rtl/h2c_sync_fifo.sv - single-clock FIFO with registered full/empty flags
module h2c_sync_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_en,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count, count_next;
  logic             do_wr, do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rptr];

  always_comb begin
    count_next = count;
    if (do_wr && !do_rd) count_next = count + (AW+1)'(1);
    if (do_rd && !do_wr) count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_en) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/h2c_stream_unpack.sv
// rtl/h2c_stream_unpack.sv - validates H2C packet headers, buffers payload beats and unpacks them into core words
module h2c_stream_unpack import h2c_pkg::*; #(
  parameter int          DATA_W     = 512,
  parameter int          OUT_W      = 64,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] MAGIC      = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_en,
  input  logic [DATA_W-1:0] s_axis_h2c_tdata,
  input  logic              s_axis_h2c_tvalid,
  input  logic              s_axis_h2c_tlast,
  output logic              s_axis_h2c_tready,
  output logic [OUT_W-1:0]  m_word_data,
  output logic              m_word_valid,
  output logic              m_word_last,
  input  logic              m_word_ready,
  input  logic              clr_status,
  output logic [ERR_W-1:0]  err_pulse,
  output logic [ERR_W-1:0]  err_status,
  output logic [31:0]       pkt_count
);

  localparam int RATIO = DATA_W / OUT_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  h2c_state_e         state;
  logic [FIELD_W-1:0] f_magic, f_len, f_seq;
  logic [FIELD_W-1:0] hdr_len, beat_cnt, expected_seq;
  logic               beat, push, last_pay;
  logic [ERR_W-1:0]   err_set;

  logic [DATA_W:0]    fifo_rd_data;
  logic               fifo_full, fifo_empty;
  logic [DATA_W-1:0]  beat_data;
  logic               beat_last, beat_valid;
  logic [IDX_W-1:0]   idx;
  logic               adv, take, final_word, load;
  logic [OUT_W-1:0]   words [RATIO];

  assign f_magic  = s_axis_h2c_tdata[HDR_MAGIC_LSB +: FIELD_W];
  assign f_len    = s_axis_h2c_tdata[HDR_LEN_LSB +: FIELD_W];
  assign f_seq    = s_axis_h2c_tdata[HDR_SEQ_LSB +: FIELD_W];

  // Ready follows the registered full flag only, so a same-cycle pop never admits a push.
  assign s_axis_h2c_tready = !rst_en && ((state != S_PAY) || !fifo_full);
  assign beat     = s_axis_h2c_tvalid && s_axis_h2c_tready;
  assign push     = beat && (state == S_PAY);
  assign last_pay = (beat_cnt == hdr_len - 16'd1);

  always_comb begin
    err_set = '0;
    if (beat && state == S_HDR) begin
      if (f_magic != MAGIC) begin
        err_set[ERR_MAGIC] = 1'b1;
      end else begin
        err_set[ERR_SEQ] = (f_seq != expected_seq);
        err_set[ERR_LEN] = ((f_len == '0) && !s_axis_h2c_tlast) ||
                           ((f_len != '0) && s_axis_h2c_tlast);
      end
    end else if (beat && state == S_PAY) begin
      err_set[ERR_LEN] = (s_axis_h2c_tlast != last_pay);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_en) begin
      state        <= S_HDR;
      hdr_len      <= '0;
      beat_cnt     <= '0;
      expected_seq <= '0;
      pkt_count    <= '0;
      err_pulse    <= '0;
      err_status   <= '0;
    end else begin
      err_pulse  <= err_set;
      err_status <= (err_status | err_pulse) & ~{ERR_W{clr_status}};
      if (beat) begin
        case (state)
          S_HDR: begin
            if (f_magic != MAGIC) begin
              state <= s_axis_h2c_tlast ? S_HDR : S_DROP;
            end else begin
              expected_seq <= f_seq + 16'd1;
              if (f_len == '0) begin
                if (s_axis_h2c_tlast) pkt_count <= pkt_count + 32'd1;
                else                  state     <= S_DROP;
              end else if (!s_axis_h2c_tlast) begin
                hdr_len  <= f_len;
                beat_cnt <= '0;
                state    <= S_PAY;
              end
            end
          end
          S_PAY: begin
            beat_cnt <= beat_cnt + 16'd1;
            if (s_axis_h2c_tlast) begin
              if (last_pay) pkt_count <= pkt_count + 32'd1;
              state <= S_HDR;
            end else if (last_pay) begin
              state <= S_DROP;
            end
          end
          S_DROP: if (s_axis_h2c_tlast) state <= S_HDR;
          default: state <= S_HDR;
        endcase
      end
    end
  end

  h2c_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_en  (rst_en),
    .wr_en   (push),
    .wr_data ({last_pay || s_axis_h2c_tlast, s_axis_h2c_tdata}),
    .rd_en   (load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  for (genvar g = 0; g < RATIO; g++) begin : g_words
    assign words[g] = beat_data[g*OUT_W +: OUT_W];
  end

  // Beat register feeds a registered output word; reload overlaps the final word to avoid a bubble.
  assign adv        = !m_word_valid || m_word_ready;
  assign take       = beat_valid && adv;
  assign final_word = take && (idx == LAST_IDX);
  assign load       = !fifo_empty && (!beat_valid || final_word);

  always_ff @(posedge clk) begin
    if (rst_en) begin
      beat_data    <= '0;
      beat_last    <= 1'b0;
      beat_valid   <= 1'b0;
      idx          <= '0;
      m_word_data  <= '0;
      m_word_valid <= 1'b0;
      m_word_last  <= 1'b0;
    end else begin
      if (load) begin
        beat_data  <= fifo_rd_data[DATA_W-1:0];
        beat_last  <= fifo_rd_data[DATA_W];
        beat_valid <= 1'b1;
        idx        <= '0;
      end else if (final_word) begin
        beat_valid <= 1'b0;
      end else if (take) begin
        idx <= idx + IDX_W'(1);
      end
      if (adv) begin
        m_word_valid <= beat_valid;
        m_word_data  <= words[idx];
        m_word_last  <= beat_valid && beat_last && (idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_h2c_stream_unpack.sv
// tb/tb_h2c_stream_unpack.sv - directed scoreboard bench for the H2C stream unpacker
module tb_h2c_stream_unpack;

  localparam logic [15:0] MAGIC = 16'hA5C3;

  logic         clk = 1'b0;
  logic         rst_en;
  logic [511:0] tdata;
  logic         tvalid, tlast, tready;
  logic [63:0]  m_word_data;
  logic         m_word_valid, m_word_last, m_word_ready;
  logic         clr_status;
  logic [2:0]   err_pulse, err_status;
  logic [31:0]  pkt_count;

  int          checks = 0;
  int          errors = 0;
  int          words_rx = 0;
  int          err_cnt [3];
  logic [64:0] exp_q [$];
  logic [64:0] mon_e;

  always #5 clk = ~clk;

  h2c_stream_unpack dut (
    .clk               (clk),
    .rst_en            (rst_en),
    .s_axis_h2c_tdata  (tdata),
    .s_axis_h2c_tvalid (tvalid),
    .s_axis_h2c_tlast  (tlast),
    .s_axis_h2c_tready (tready),
    .m_word_data       (m_word_data),
    .m_word_valid      (m_word_valid),
    .m_word_last       (m_word_last),
    .m_word_ready      (m_word_ready),
    .clr_status        (clr_status),
    .err_pulse         (err_pulse),
    .err_status        (err_status),
    .pkt_count         (pkt_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_en) begin
      for (int i = 0; i < 3; i++) if (err_pulse[i]) err_cnt[i]++;
      if (m_word_valid && m_word_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(m_word_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", m_word_data, mon_e[63:0]);
          check("word_last", 64'(m_word_last), 64'(mon_e[64]));
          words_rx++;
        end
      end
    end
  end

  function automatic logic [511:0] rand_beat();
    logic [511:0] b = '0;
    for (int i = 0; i < 16; i++) b = {b[479:0], 32'($urandom())};
    return b;
  endfunction

  function automatic logic [511:0] mk_hdr(input logic [15:0] magic, input logic [15:0] len,
                                          input logic [15:0] seq);
    logic [511:0] h = rand_beat();
    h[15:0]  = magic;
    h[31:16] = len;
    h[47:32] = seq;
    return h;
  endfunction

  task automatic push_words(input logic [511:0] d, input logic lst);
    for (int w = 0; w < 8; w++) exp_q.push_back({lst && (w == 7), 64'(d >> (w * 64))});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [511:0] d, input logic l);
    bit ok = 1'b0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = tready;
      step();
    end
    tvalid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL tready_timeout observed=0 expected=1");
    end
  endtask

  task automatic send_pkt(input logic [15:0] seq, input int len);
    logic [511:0] d;
    send_beat(mk_hdr(MAGIC, 16'(len), seq), len == 0);
    for (int k = 0; k < len; k++) begin
      d = rand_beat();
      push_words(d, k == len - 1);
      send_beat(d, k == len - 1);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || m_word_valid) && n < 3000) begin
      step();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    repeat (3) step();
  endtask

  task automatic clear_status();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    @(negedge clk);
    check("err_status_cleared", 64'(err_status), 64'd0);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, 64'(tready), 64'd0);
    check({tag, "_valid"}, 64'(m_word_valid), 64'd0);
    check({tag, "_data"}, m_word_data, 64'd0);
    check({tag, "_last"}, 64'(m_word_last), 64'd0);
    check({tag, "_err_pulse"}, 64'(err_pulse), 64'd0);
    check({tag, "_err_status"}, 64'(err_status), 64'd0);
    check({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
  endtask

  initial begin
    logic [511:0] d;
    logic [64:0]  head;
    int           base, acc;

    for (int i = 0; i < 3; i++) err_cnt[i] = 0;
    rst_en = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    m_word_ready = 1'b1; clr_status = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst_en = 1'b0;
    @(negedge clk);
    check("idle_tready", 64'(tready), 64'd1);
    step();

    // T1: good two-beat packet, with word-0 latency probe on the first beat
    send_beat(mk_hdr(MAGIC, 16'd2, 16'd0), 1'b0);
    d = rand_beat();
    push_words(d, 1'b0);
    send_beat(d, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("latency_1clk_not_valid", 64'(m_word_valid), 64'd0);
    @(negedge clk);
    check("latency_2clk_valid", 64'(m_word_valid), 64'd1);
    step();
    d = rand_beat();
    push_words(d, 1'b1);
    send_beat(d, 1'b1);
    drain("t1_drain");
    check("t1_pkt_count", 64'(pkt_count), 64'd1);
    check("t1_words", 64'(words_rx), 64'd16);
    check("t1_err_magic", 64'(err_cnt[0]), 64'd0);
    check("t1_err_len", 64'(err_cnt[1]), 64'd0);
    check("t1_err_seq", 64'(err_cnt[2]), 64'd0);

    // T2: bad magic is dropped through tlast, then a good packet follows
    base = words_rx;
    send_beat(mk_hdr(16'h1234, 16'd3, 16'd1), 1'b0);
    for (int k = 0; k < 3; k++) send_beat(rand_beat(), k == 2);
    repeat (6) step();
    check("t2_err_magic", 64'(err_cnt[0]), 64'd1);
    check("t2_no_words", 64'(words_rx), 64'(base));
    check("t2_pkt_count_hold", 64'(pkt_count), 64'd1);
    send_pkt(16'd1, 1);
    drain("t2_drain");
    check("t2_pkt_count", 64'(pkt_count), 64'd2);
    check("t2_words", 64'(words_rx), 64'(base + 8));

    // T3: len=4 with early tlast on the second payload beat
    base = words_rx;
    send_beat(mk_hdr(MAGIC, 16'd4, 16'd2), 1'b0);
    d = rand_beat();
    push_words(d, 1'b0);
    send_beat(d, 1'b0);
    d = rand_beat();
    push_words(d, 1'b1);
    send_beat(d, 1'b1);
    drain("t3_drain");
    check("t3_err_len", 64'(err_cnt[1]), 64'd1);
    check("t3_words", 64'(words_rx), 64'(base + 16));
    check("t3_pkt_count_hold", 64'(pkt_count), 64'd2);
    send_pkt(16'd3, 1);
    drain("t3_recover_drain");
    check("t3_pkt_count", 64'(pkt_count), 64'd3);

    // T4: sequence jump sets the sticky seq bit until cleared
    clear_status();
    base = words_rx;
    send_pkt(16'd4, 1);
    send_pkt(16'd9, 1);
    drain("t4_drain");
    check("t4_err_seq", 64'(err_cnt[2]), 64'd1);
    check("t4_pkt_count", 64'(pkt_count), 64'd5);
    check("t4_words", 64'(words_rx), 64'(base + 16));
    check("t4_err_status", 64'(err_status), 64'd4);
    repeat (5) step();
    check("t4_err_status_sticky", 64'(err_status), 64'd4);
    clear_status();

    // T5: consumer stalled while a 20-beat packet arrives
    base = words_rx;
    m_word_ready = 1'b0;
    send_beat(mk_hdr(MAGIC, 16'd20, 16'd10), 1'b0);
    acc = 0;
    d = rand_beat();
    for (int c = 0; c < 60 && acc < 19; c++) begin
      tdata = d; tlast = 1'b0; tvalid = 1'b1;
      @(negedge clk);
      if (tready) begin
        push_words(d, 1'b0);
        acc++;
        d = rand_beat();
      end
      step();
    end
    tvalid = 1'b0;
    check("t5_beats_before_stall", 64'(acc), 64'd17);
    @(negedge clk);
    head = exp_q[0];
    check("t5_tready_low", 64'(tready), 64'd0);
    check("t5_hold_valid", 64'(m_word_valid), 64'd1);
    check("t5_hold_data", m_word_data, head[63:0]);
    step();
    m_word_ready = 1'b1;
    for (int k = acc; k < 20; k++) begin
      push_words(d, k == 19);
      send_beat(d, k == 19);
      d = rand_beat();
    end
    drain("t5_drain");
    check("t5_words", 64'(words_rx), 64'(base + 160));
    check("t5_pkt_count", 64'(pkt_count), 64'd6);

    // T6: reset mid-payload discards buffered beats
    m_word_ready = 1'b0;
    send_beat(mk_hdr(MAGIC, 16'd4, 16'd11), 1'b0);
    send_beat(rand_beat(), 1'b0);
    send_beat(rand_beat(), 1'b0);
    rst_en = 1'b1;
    step();
    @(negedge clk);
    check_reset_outputs("midrst");
    step();
    rst_en = 1'b0;
    m_word_ready = 1'b1;
    base = words_rx;
    repeat (5) step();
    check("t6_no_stale_words", 64'(words_rx), 64'(base));
    check("t6_tready", 64'(tready), 64'd1);
    send_pkt(16'd0, 2);
    drain("t6_drain");
    check("t6_words", 64'(words_rx), 64'(base + 16));
    check("t6_pkt_count", 64'(pkt_count), 64'd1);
    check("t6_err_seq", 64'(err_cnt[2]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/h2c_stream_unpack.md
Name: h2c_stream_unpack

Overview:
- Host-to-card receive path: the reverse direction of the C2H send path.
- Accepts XDMA H2C AXI-Stream beats from the host and validates a one-beat packet header (magic, length, sequence).
- Buffers payload beats in a small FIFO and unpacks each DATA_W beat into OUT_W words for the core-side consumer.
- Sits between the XDMA H2C stream and simulation_top core logic, in the same clock domain as the DMA stream.

Parameters:
DATA_W, 512, H2C stream beat width in bits
OUT_W, 64, core-side word width; DATA_W must be an integer multiple (RATIO = DATA_W/OUT_W)
FIFO_DEPTH, 16, payload buffer depth in beats (power of two)
MAGIC, 16'hA5C3, required header magic value

Ports:
clk  in  1  single clock, DMA stream domain
rst_en  in  1  synchronous, active-high reset
s_axis_h2c_tdata  in  DATA_W  H2C beat data
s_axis_h2c_tvalid  in  1  beat valid
s_axis_h2c_tlast  in  1  last beat of packet
s_axis_h2c_tready  out  1  beat accept
m_word_data  out  OUT_W  unpacked word
m_word_valid  out  1  word valid
m_word_last  out  1  final word of packet payload
m_word_ready  in  1  consumer accept
clr_status  in  1  clears sticky error bits
err_pulse  out  3  one-cycle pulses {seq, len, magic}
err_status  out  3  sticky OR of err_pulse, cleared by clr_status
pkt_count  out  32  packets completed with no length/magic error, wraps at 2^32

Behaviour:
- Reset state: all outputs are 0, state S_HDR, FIFO empty, unpacker empty, expected_seq 0. Reset mid-packet discards all buffered data.
- Header beat fields: [15:0] magic, [31:16] len (payload beats), [47:32] seq. All other bits are ignored.
- Beat transfer occurs on tvalid & tready. Word transfer occurs on m_word_valid & m_word_ready.
- S_HDR: tready=1.
  - Bad magic: pulse err_pulse[0]; go to S_HDR if tlast, else S_DROP.
  - Good magic, seq != expected_seq: pulse err_pulse[2] and accept anyway. expected_seq <= seq+1 on every good-magic header, 16-bit wrap.
  - Good magic, len==0: tlast must be 1. If so, pkt_count++ and stay in S_HDR. If not, pulse err_pulse[1] and go to S_DROP.
  - Good magic, len>0, tlast=1: pulse err_pulse[1] and stay in S_HDR.
  - Otherwise: beat_cnt <= 0 and go to S_PAY.
- S_PAY: tready = !fifo_full. Every accepted beat is pushed with a last flag = (beat_cnt==len-1) | tlast.
  - tlast at beat_cnt==len-1: pkt_count++ and go to S_HDR.
  - tlast early: pulse err_pulse[1] and go to S_HDR. Pushed beats are still delivered.
  - beat_cnt==len-1 without tlast: pulse err_pulse[1] and go to S_DROP.
- S_DROP: tready=1. Discard beats until tlast, then go to S_HDR. Nothing is pushed.
- Unpacker: loads a FIFO entry when it is empty, or on the cycle its final word transfers (no bubble between beats).
  - Words are emitted LSB first, index 0..RATIO-1.
  - m_word_last=1 only on word RATIO-1 of an entry whose last flag is set.
  - data, valid and last are held stable while valid & !ready.
- Latency: word 0 is valid exactly 2 clk after the accepting edge of a payload beat when the FIFO and unpacker are idle.
- Throughput: sustained 1 word/clk on the output. Input back-pressures only when the FIFO is full.
- Simultaneous FIFO push and pop when full: the pop frees the slot, but tready is computed from the registered full flag, so no push that cycle.
- err_status: err_status <= (err_status | err_pulse) & ~{3{clr_status}}. A pulse in the same cycle as clr_status is lost; clear has priority.

Decomposition:
- Package h2c_pkg: header field offsets/widths, MAGIC default, state enum {S_HDR, S_PAY, S_DROP}, error bit indices.
- Sub-module h2c_sync_fifo: single-clock FIFO, width DATA_W+1, registered full/empty, synchronous reset.

Test Plan:
1. Header {seq=0, len=2, magic=A5C3} plus 2 payload beats, tlast on beat 2, ready=1 -> 16 words in LSB-first order, m_word_last only on word 16, pkt_count=1, err_pulse never set.
2. Header with magic=1234, len=3, followed by 3 beats ending in tlast -> err_pulse[0] for 1 cycle, no words output, pkt_count unchanged, next good packet is accepted normally.
3. Header len=4 with tlast on payload beat 2 -> err_pulse[1], 16 words output with last on word 16, state returns to S_HDR.
4. Two good packets with seq 0 then 5 -> err_pulse[2] on the second header, both payloads delivered, pkt_count=2, err_status=3'b100 until clr_status.
5. m_word_ready held 0 while a 20-beat packet is sent -> tready drops after 16 accepted beats plus the unpacker load. Releasing ready delivers all 160 words in order, none lost or duplicated.
6. rst_en asserted mid-payload -> next cycle all outputs are 0 and the FIFO is empty. A new packet after release is delivered correctly.
